// File: rtl/serial_transmitter.sv
// Byte-wide asynchronous serial transmitter: start bit, 8 data bits LSB first,
// optional parity bit, stop bit; every bit held for CLKS_PER_BIT clocks.
module serial_transmitter #(
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [9:0] LAST_TICK = 10'(CLKS_PER_BIT - 1);

    state_t     state_q, state_d;
    logic [9:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shreg_q, shreg_d;
    logic       line_q, line_d;
    logic       done_q, done_d;
    logic       bit_end;

    function automatic logic parity_bit(input logic [7:0] b);
        return (^b) ^ (PARITY_ODD != 0);
    endfunction

    assign bit_end = (tick_q == LAST_TICK);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        line_d  = 1'b1;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                if (tx_valid) begin
                    shreg_d = tx_data;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) tick_d = bit_end ? 10'd0 : tick_q + 10'd1;

        // Line level is registered from the next state so it changes with the state.
        case (state_d)
            START:   line_d = 1'b0;
            DATA:    line_d = shreg_d[bit_d];
            PARITY:  line_d = parity_bit(shreg_q);
            default: line_d = 1'b1;
        endcase

        done_d = (state_q == STOP) && (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            line_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            line_q  <= line_d;
            done_q  <= done_d;
        end
    end

    assign tx_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign serial_out = line_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_serial_transmitter.sv
// Scoreboard bench: the driver predicts acceptance and queues expected frames;
// a monitor follows the line and compares each cycle against the queued frame.
module tb_serial_transmitter;

    localparam int CPB = 4;
    localparam int PE  = 1;
    localparam int PO  = 0;
    localparam int NB  = 10 + PE;
    localparam int L   = NB * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, serial_out, busy, tx_done;

    int checks = 0;
    int errors = 0;
    int W = 0;
    logic mon_en = 1'b0;
    logic [10:0] q[$];

    serial_transmitter #(.CLKS_PER_BIT(CPB), .PARITY_EN(PE), .PARITY_ODD(PO)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .serial_out(serial_out), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Frame as transmitted, bit 0 first: start, data LSB first, optional parity, stop.
    function automatic logic [10:0] mk_frame(input logic [7:0] d);
        logic [10:0] fr;
        logic par;
        par = (($countones(d) % 2) == 1) ^ (PO != 0);
        fr = {2'b11, d, 1'b0};
        if (PE != 0) fr[9] = par;
        return fr;
    endfunction

    task automatic cyc(input logic v, input logic [7:0] d);
        logic acc;
        tx_valid = v;
        tx_data  = d;
        chk("tx_ready", {7'd0, tx_ready}, {7'd0, W == 0});
        acc = v && (W == 0);
        @(posedge clk);
        if (acc) begin
            q.push_back(mk_frame(d));
            W = L;
        end else if (W > 0) begin
            W--;
        end
        @(negedge clk);
    endtask

    // Monitor
    int          pos = 0;
    logic        in_frame = 1'b0;
    logic [10:0] expf = '0;

    always begin
        @(posedge clk);
        #2;
        if (!mon_en) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && serial_out == 1'b0) begin
                if (q.size() == 0) begin
                    chk("unexpected_start", 8'd1, 8'd0);
                    expf = 11'h7FF;
                end else begin
                    expf = q.pop_front();
                end
                in_frame = 1'b1;
                pos = 0;
            end
            if (in_frame) begin
                if (pos < L) begin
                    chk($sformatf("line_bit%0d", pos / CPB), {7'd0, serial_out}, {7'd0, expf[pos / CPB]});
                    chk("busy_in_frame", {7'd0, busy}, 8'd1);
                    chk("done_in_frame", {7'd0, tx_done}, 8'd0);
                    pos++;
                end else begin
                    chk("line_after_stop", {7'd0, serial_out}, 8'd1);
                    chk("busy_after_stop", {7'd0, busy}, 8'd0);
                    chk("tx_done_pulse", {7'd0, tx_done}, 8'd1);
                    in_frame = 1'b0;
                end
            end else begin
                chk("busy_idle", {7'd0, busy}, 8'd0);
                chk("done_idle", {7'd0, tx_done}, 8'd0);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hAA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_line", {7'd0, serial_out}, 8'd1);
        chk("rst_ready", {7'd0, tx_ready}, 8'd1);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, tx_done}, 8'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Held valid accepted on the first edge, live data scrambled in flight.
        cyc(1'b1, 8'hA5);
        repeat (L + 2) cyc(1'b0, 8'($urandom));
        cyc(1'b1, 8'h07);
        repeat (L + 2) cyc(1'b0, 8'($urandom));
        cyc(1'b1, 8'h3C);
        cyc(1'b1, 8'hC3);
        repeat (L + 1) cyc(1'b0, 8'hC3);
        // Back-to-back frames with valid held high.
        cyc(1'b1, 8'h00);
        repeat (L + 1) cyc(1'b1, 8'hFF);
        repeat (L + 2) cyc(1'b0, 8'h00);

        // Abort during data bit 3, with valid high on the reset edge.
        cyc(1'b1, 8'h5A);
        repeat (4 * CPB + 1) cyc(1'b0, 8'h00);
        mon_en   = 1'b0;
        reset    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h77;
        @(posedge clk);
        @(negedge clk);
        chk("abort_line", {7'd0, serial_out}, 8'd1);
        chk("abort_ready", {7'd0, tx_ready}, 8'd1);
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_done", {7'd0, tx_done}, 8'd0);
        reset    = 1'b0;
        tx_valid = 1'b0;
        W        = 0;
        mon_en   = 1'b1;
        repeat (L + 2) cyc(1'b0, 8'h00);

        repeat (500) cyc($urandom_range(0, 3) != 0, 8'($urandom));
        repeat (L + 5) cyc(1'b0, 8'h00);
        chk("queue_drained", 8'(q.size()), 8'd0);
        chk("monitor_idle", {7'd0, in_frame}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_transmitter.md
SERIAL_TRANSMITTER -- requirements
Module: serial_transmitter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1: clock cycles per serial bit; legal range 1..1023.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts a parity bit between data and stop bit.
REQ-003 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
REQ-004 clk  input  1  clock; all state SHALL change on the rising edge only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tx_data  input  8  byte to send; sampled only on acceptance.
REQ-007 tx_valid  input  1  the upstream block offers tx_data.
REQ-008 tx_ready  output  1  the block can accept a byte; high only in IDLE.
REQ-009 serial_out  output  1  registered line output; idle level 1.
REQ-010 busy  output  1  high while a frame is in progress (START through STOP).
REQ-011 tx_done  output  1  one-cycle pulse after the stop bit completes.

Function
REQ-012 The state machine SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-013 Acceptance SHALL occur on the rising edge where tx_valid=1 and tx_ready=1. On that edge the block SHALL latch tx_data into the shift register and enter START.
REQ-014 tx_ready SHALL equal (state==IDLE) and SHALL NOT depend combinationally on tx_valid.
REQ-015 serial_out SHALL be driven by a register:
  - 0 during START
  - data bits in DATA, LSB first
  - the parity bit in PARITY
  - 1 in STOP and IDLE
REQ-016 Each of START, each data bit, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles. This SHALL be timed by a bit-period counter that resets to 0 at every bit boundary.
REQ-017 A 3-bit data bit counter SHALL advance once per bit period in DATA. The transition out of DATA SHALL occur after bit 7 has been held for its full period.
REQ-018 Transitions:
  - START -> DATA
  - DATA -> PARITY if PARITY_EN=1, otherwise DATA -> STOP
  - PARITY -> STOP
  - STOP -> IDLE
REQ-019 The parity bit SHALL be the XOR of the 8 latched bits, inverted when PARITY_ODD=1. It SHALL be computed from the latched copy, not from the live tx_data.
REQ-020 Changes on tx_data or tx_valid after acceptance SHALL have no effect on the frame in flight.
REQ-021 tx_done SHALL be 1 for exactly the one cycle in which the state is IDLE immediately after STOP, and 0 at all other times.
REQ-022 busy SHALL be 1 exactly when the state is not IDLE.
REQ-023 Frame length from the acceptance edge to the return to IDLE SHALL be (10+PARITY_EN)*CLKS_PER_BIT cycles.
REQ-024 At least one IDLE cycle (line=1) SHALL separate back-to-back frames. The minimum frame-to-frame period SHALL therefore be (10+PARITY_EN)*CLKS_PER_BIT+1 cycles.
REQ-025 tx_valid=1 held in IDLE SHALL be accepted on the first edge; a byte SHALL never be accepted twice per handshake.

Reset
REQ-026 With reset=1 at a rising edge, the block SHALL enter IDLE with:
  - serial_out=1, tx_ready=1, busy=0, tx_done=0
  - bit-period counter, data bit counter and shift register all 0
REQ-027 Reset asserted mid-frame SHALL abort the frame: serial_out=1 from the next cycle and no tx_done pulse.
REQ-028 Reset SHALL take priority over a simultaneous acceptance; no byte is accepted on a reset edge.

Verification
REQ-029 CLKS_PER_BIT=1, PARITY_EN=0; send 0xA5 -> serial_out over 10 cycles = 0,1,0,1,0,0,1,0,1,1. Then tx_done=1 for one cycle and tx_ready=1.
REQ-030 CLKS_PER_BIT=4, PARITY_EN=1, PARITY_ODD=0; send 0x07 -> each bit held 4 cycles; parity bit=1; busy high for 44 cycles.
REQ-031 tx_valid held high with 0x00 then 0xFF -> two frames separated by exactly one IDLE cycle at line 1. The second frame's data bits are all 1.
REQ-032 tx_data changed from 0x3C to 0xC3 one cycle after acceptance -> the transmitted bits are 0x3C (0,0,1,1,1,1,0,0 LSB first).
REQ-033 Reset asserted during data bit 3 -> the next cycle shows serial_out=1, tx_ready=1, busy=0, and no tx_done pulse.
REQ-034 PARITY_ODD=1, send 0x00 -> parity bit=1; send 0x01 -> parity bit=0.
